// File: rtl/acq_sequencer.sv
// Acquisition sequencer: arms on start, waits for a software or external trigger,
// optionally delays, fires the generator trigger and stops it on the last tlast.
module acq_sequencer #(
  parameter int CNT_WIDTH     = 32,
  parameter int PKT_CNT_WIDTH = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     aclk,
  input  logic                     resetn,
  input  logic                     ctl_start,
  input  logic                     ctl_abort,
  input  logic                     cfg_trig_src,
  input  logic [CNT_WIDTH-1:0]     cfg_delay,
  input  logic [PKT_CNT_WIDTH-1:0] cfg_num_pkts,
  input  logic                     ext_trig,
  input  logic                     mon_tvalid,
  input  logic                     mon_tready,
  input  logic                     mon_tlast,
  output logic                     dp_trig,
  output logic                     dp_resetn,
  output logic                     sts_busy,
  output logic                     sts_armed,
  output logic                     sts_done,
  output logic                     sts_aborted,
  output logic [PKT_CNT_WIDTH-1:0] sts_pkt_count,
  output logic [CNT_WIDTH-1:0]     sts_stall_cycles
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DELAY, S_RUN} state_t;

  localparam logic [CNT_WIDTH-1:0]     CNT_ONE = 1;
  localparam logic [CNT_WIDTH-1:0]     CNT_MAX = '1;
  localparam logic [PKT_CNT_WIDTH-1:0] PKT_ONE = 1;

  state_t                     state_q, state_d;
  logic                       cfg_trig_src_q;
  logic [CNT_WIDTH-1:0]       cfg_delay_q;
  logic [PKT_CNT_WIDTH-1:0]   cfg_num_pkts_q;
  logic [CNT_WIDTH-1:0]       delay_cnt_q;
  logic [SYNC_STAGES-1:0]     sync_q;
  logic                       sync_prev_q;
  logic                       ext_edge_q;
  logic                       dp_trig_q;
  logic                       done_q;
  logic                       aborted_q;
  logic [PKT_CNT_WIDTH-1:0]   pkt_count_q;
  logic [CNT_WIDTH-1:0]       stall_q;

  logic                       start_ok, abort_ok, trig_event, hs, final_hs;
  logic [PKT_CNT_WIDTH-1:0]   pkt_count_inc;

  assign start_ok      = ctl_start && (state_q == S_IDLE);
  assign abort_ok      = ctl_abort && (state_q != S_IDLE);
  // ext_edge_q is a single-cycle pulse, so edges seen outside ARMED simply expire.
  assign trig_event    = (state_q == S_ARMED) && (cfg_trig_src_q ? ext_edge_q : 1'b1);
  assign hs            = (state_q == S_RUN) && mon_tvalid && mon_tready && mon_tlast;
  assign pkt_count_inc = pkt_count_q + PKT_ONE;
  assign final_hs      = hs && (cfg_num_pkts_q != '0) && (pkt_count_inc == cfg_num_pkts_q);

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok) state_d = S_ARMED;
      S_ARMED: begin
        if (abort_ok)                 state_d = S_IDLE;
        else if (trig_event)          state_d = (cfg_delay_q == '0) ? S_RUN : S_DELAY;
      end
      S_DELAY: begin
        if (abort_ok)                 state_d = S_IDLE;
        else if (delay_cnt_q == CNT_ONE) state_d = S_RUN;
      end
      S_RUN: begin
        // Completion beats a coincident abort.
        if (final_hs || abort_ok)     state_d = S_IDLE;
      end
      default:                        state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      state_q        <= S_IDLE;
      cfg_trig_src_q <= 1'b0;
      cfg_delay_q    <= '0;
      cfg_num_pkts_q <= '0;
      delay_cnt_q    <= '0;
      sync_q         <= '0;
      sync_prev_q    <= 1'b0;
      ext_edge_q     <= 1'b0;
      dp_trig_q      <= 1'b0;
      done_q         <= 1'b0;
      aborted_q      <= 1'b0;
      pkt_count_q    <= '0;
      stall_q        <= '0;
    end else begin
      state_q     <= state_d;
      sync_q      <= {sync_q[SYNC_STAGES-2:0], ext_trig};
      sync_prev_q <= sync_q[SYNC_STAGES-1];
      ext_edge_q  <= sync_q[SYNC_STAGES-1] && !sync_prev_q;
      dp_trig_q   <= (state_d == S_RUN) && (state_q != S_RUN);
      done_q      <= final_hs;

      if (start_ok) begin
        cfg_trig_src_q <= cfg_trig_src;
        cfg_delay_q    <= cfg_delay;
        cfg_num_pkts_q <= cfg_num_pkts;
        aborted_q      <= 1'b0;
        pkt_count_q    <= '0;
        stall_q        <= '0;
      end else begin
        if (abort_ok && !final_hs) aborted_q <= 1'b1;
        if (hs) pkt_count_q <= pkt_count_inc;
        if ((state_q == S_RUN) && mon_tvalid && !mon_tready && (stall_q != CNT_MAX))
          stall_q <= stall_q + CNT_ONE;
      end

      if (trig_event)               delay_cnt_q <= cfg_delay_q;
      else if (state_q == S_DELAY)  delay_cnt_q <= delay_cnt_q - CNT_ONE;
    end
  end

  // The final handshake drops dp_resetn in its own cycle so nothing passes after the last tlast.
  assign dp_resetn        = (state_q != S_IDLE) && !final_hs;
  assign dp_trig          = dp_trig_q;
  assign sts_busy         = (state_q != S_IDLE);
  assign sts_armed        = (state_q == S_ARMED);
  assign sts_done         = done_q;
  assign sts_aborted      = aborted_q;
  assign sts_pkt_count    = pkt_count_q;
  assign sts_stall_cycles = stall_q;

endmodule
